// File: rtl/key_event_ctrl.sv
// Turns debounced active-low key levels into short/long press events.
// Events are arbitrated round-robin into a show-ahead FIFO with valid/ready.
module key_event_ctrl #(
   parameter int NUM_KEYS   = 4,
   parameter int FREQ       = 50,
   parameter int LONG_MS    = 1000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_level,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [2:0]          evt_key,
   output logic                evt_type,
   output logic                evt_overflow,
   input  logic                clr_overflow
);
   localparam int TICK_DIV = FREQ * 1000;
   localparam int PW       = $clog2(TICK_DIV);
   localparam int KW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} key_state_t;

   logic [PW-1:0]       presc_reg;
   logic                tick;
   logic [NUM_KEYS-1:0] key_q_reg, prev_reg;
   logic [NUM_KEYS-1:0] press_vec, release_vec;
   logic [NUM_KEYS-1:0] post_vec, post_type_vec;
   logic [NUM_KEYS-1:0] pending_reg, pend_type_reg;
   logic [NUM_KEYS-1:0] grant_vec;
   logic                grant_valid, grant_type, drop;
   logic [KW-1:0]       grant_idx, rr_ptr_reg, rr_ptr_next;
   int                  arb_idx;
   logic                overflow_reg;

   logic [3:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]         count_reg;
   logic                fifo_full, fifo_empty, pop, can_push;
   logic [3:0]          head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       presc_reg <= '0;
      else if (tick) presc_reg <= '0;
      else           presc_reg <= presc_reg + PW'(1);
   end
   assign tick = (presc_reg == PW'(TICK_DIV - 1));

   // key_q is the sampled level; prev is its one-cycle-old copy.
   assign press_vec   = prev_reg & ~key_q_reg;
   assign release_vec = ~prev_reg & key_q_reg;

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_state_t  state_reg, state_next;
         logic [11:0] ms_cnt_reg, ms_cnt_next;
         logic        post_k, type_k;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_reg  <= S_IDLE;
               ms_cnt_reg <= '0;
            end else begin
               state_reg  <= state_next;
               ms_cnt_reg <= ms_cnt_next;
            end
         end

         always_comb begin
            state_next  = state_reg;
            ms_cnt_next = ms_cnt_reg;
            post_k      = 1'b0;
            type_k      = 1'b0;
            case (state_reg)
               S_IDLE: begin
                  if (press_vec[gi]) begin
                     state_next  = S_PRESSED;
                     ms_cnt_next = '0;
                  end
               end
               S_PRESSED: begin
                  // Reaching the long threshold wins over a coincident release.
                  if (tick && ms_cnt_reg == 12'(LONG_MS - 1)) begin
                     post_k     = 1'b1;
                     type_k     = 1'b1;
                     state_next = release_vec[gi] ? S_IDLE : S_HELD;
                  end else if (release_vec[gi]) begin
                     post_k     = 1'b1;
                     state_next = S_IDLE;
                  end else if (tick) begin
                     ms_cnt_next = ms_cnt_reg + 12'd1;
                  end
               end
               S_HELD: begin
                  if (release_vec[gi]) state_next = S_IDLE;
               end
               default: state_next = S_IDLE;
            endcase
         end

         assign post_vec[gi]      = post_k;
         assign post_type_vec[gi] = type_k;
      end
   endgenerate

   assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign pop        = !fifo_empty && evt_ready;
   assign can_push   = !fifo_full || pop;

   always_comb begin
      grant_vec   = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      arb_idx     = 0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         arb_idx = (int'(rr_ptr_reg) + i) % NUM_KEYS;
         if (can_push && !grant_valid && pending_reg[arb_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = KW'(arb_idx);
         end
      end
      if (grant_valid) grant_vec[grant_idx] = 1'b1;
      rr_ptr_next = KW'((int'(grant_idx) + 1) % NUM_KEYS);
   end

   assign grant_type = pend_type_reg[grant_idx];
   // A slot granted this cycle is free to take a new post without loss.
   assign drop       = |(post_vec & pending_reg & ~grant_vec);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q_reg     <= '1;
         prev_reg      <= '1;
         pending_reg   <= '0;
         pend_type_reg <= '0;
         rr_ptr_reg    <= '0;
         overflow_reg  <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
      end else begin
         key_q_reg     <= key_level;
         prev_reg      <= key_q_reg;
         pending_reg   <= (pending_reg & ~grant_vec) | post_vec;
         pend_type_reg <= (pend_type_reg & ~post_vec) | (post_type_vec & post_vec);
         if (grant_valid) rr_ptr_reg <= rr_ptr_next;
         if (drop)              overflow_reg <= 1'b1;
         else if (clr_overflow) overflow_reg <= 1'b0;
         if (grant_valid) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)         rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (grant_valid && !pop)      count_reg <= count_reg + (AW+1)'(1);
         else if (!grant_valid && pop) count_reg <= count_reg - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (grant_valid) mem[wr_ptr_reg] <= {3'(grant_idx), grant_type};
   end

   assign head         = mem[rd_ptr_reg];
   assign evt_valid    = !fifo_empty;
   assign evt_key      = evt_valid ? head[3:1] : 3'd0;
   assign evt_type     = evt_valid ? head[0] : 1'b0;
   assign evt_overflow = overflow_reg;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: expected events are queued as stimulus
// is applied and compared in order as the DUT hands them out.
module tb_key_event_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_level = 4'b1111;
   logic       evt_ready = 1'b1;
   logic       clr_overflow = 1'b0;
   logic       evt_valid;
   logic [2:0] evt_key;
   logic       evt_type;
   logic       evt_overflow;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int ev_count = 0;
   logic [3:0] sb [$];

   always #5 clk = ~clk;

   key_event_ctrl #(
      .NUM_KEYS(4), .FREQ(1), .LONG_MS(3), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .key_level(key_level),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_key(evt_key), .evt_type(evt_type),
      .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_evt(input int k, input logic t);
      logic [2:0] kk;
      kk = 3'(k);
      sb.push_back({kk, t});
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while (sb.size() != 0 && i < budget) begin
         step(1);
         i++;
      end
      check("drain_queue_empty", 32'(sb.size()), 32'd0);
   endtask

   // Handshake monitor: a transfer happens on the next posedge.
   always @(negedge clk) begin
      if (!rst && evt_valid === 1'b1 && evt_ready) begin
         logic [3:0] exp;
         ev_count++;
         if (sb.size() == 0) begin
            check("evt_unexpected", 32'({evt_key, evt_type}), 32'hDEAD);
         end else begin
            exp = sb.pop_front();
            check("evt_key_type", 32'({evt_key, evt_type}), 32'(exp));
         end
      end
   end

   initial begin
      int t;
      int ev_before;
      logic [3:0] kl;

      step(3);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_key", 32'(evt_key), 32'd0);
      check("rst_type", 32'(evt_type), 32'd0);
      check("rst_overflow", 32'(evt_overflow), 32'd0);
      rst = 1'b0;
      step(5000);
      check("idle_no_events", 32'(ev_count), 32'd0);

      // Keys 0 and 3 released together, pointer at 0.
      key_level = 4'b0110;
      step(100);
      expect_evt(0, 1'b0);
      expect_evt(3, 1'b0);
      key_level = 4'b1111;
      step(3);
      check("simul0_first_valid", 32'(evt_valid), 32'd1);
      check("simul0_first_key", 32'(evt_key), 32'd0);
      step(1);
      check("simul0_second_valid", 32'(evt_valid), 32'd1);
      check("simul0_second_key", 32'(evt_key), 32'd3);
      step(1);
      check("simul0_empty", 32'(evt_valid), 32'd0);

      // Single key-0 event moves the pointer to 1.
      key_level = 4'b1110;
      step(50);
      expect_evt(0, 1'b0);
      key_level = 4'b1111;
      drain(20);

      key_level = 4'b0110;
      step(100);
      expect_evt(3, 1'b0);
      expect_evt(0, 1'b0);
      key_level = 4'b1111;
      step(3);
      check("simul1_first_key", 32'(evt_key), 32'd3);
      step(1);
      check("simul1_second_key", 32'(evt_key), 32'd0);
      step(1);
      check("simul1_empty", 32'(evt_valid), 32'd0);

      // Short press on key 2 with latency check.
      key_level = 4'b1011;
      step(1500);
      expect_evt(2, 1'b0);
      key_level = 4'b1111;
      step(2);
      check("short_latency_early", 32'(evt_valid), 32'd0);
      step(1);
      check("short_latency_valid", 32'(evt_valid), 32'd1);
      check("short_key", 32'(evt_key), 32'd2);
      check("short_type", 32'(evt_type), 32'd0);
      drain(20);

      // Long press on key 1.
      expect_evt(1, 1'b1);
      key_level = 4'b1101;
      t = 0;
      while (evt_valid !== 1'b1 && t < 5000) begin
         step(1);
         t++;
      end
      check("long_seen", 32'(evt_valid), 32'd1);
      check("long_window", 32'(t >= 2000 && t <= 4000), 32'd1);
      step(10000 - t);
      ev_before = ev_count;
      key_level = 4'b1111;
      step(200);
      check("long_release_silent", 32'(ev_count), 32'(ev_before));
      drain(20);

      // Fill the FIFO with the consumer stalled, then overflow key 0.
      evt_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         kl = 4'b1111;
         kl[k] = 1'b0;
         key_level = kl;
         step(10);
         key_level = 4'b1111;
         expect_evt(k, 1'b0);
         step(10);
      end
      check("full_valid", 32'(evt_valid), 32'd1);
      check("full_head_key", 32'(evt_key), 32'd0);
      key_level = 4'b1110;
      step(10);
      key_level = 4'b1111;
      expect_evt(0, 1'b0);
      step(10);
      check("pending_no_overflow", 32'(evt_overflow), 32'd0);
      key_level = 4'b1110;
      step(10);
      key_level = 4'b1111;
      step(10);
      check("drop_overflow", 32'(evt_overflow), 32'd1);
      ev_before = ev_count;
      evt_ready = 1'b1;
      drain(50);
      step(2);
      check("full_drained_count", 32'(ev_count - ev_before), 32'd5);
      check("full_drained_empty", 32'(evt_valid), 32'd0);
      check("overflow_sticky", 32'(evt_overflow), 32'd1);
      clr_overflow = 1'b1;
      step(1);
      clr_overflow = 1'b0;
      check("overflow_cleared", 32'(evt_overflow), 32'd0);

      // Reset in the middle of a long press with two events queued.
      evt_ready = 1'b0;
      key_level = 4'b1011;
      step(10);
      key_level = 4'b1111;
      step(10);
      key_level = 4'b0111;
      step(10);
      key_level = 4'b1111;
      step(10);
      key_level = 4'b1101;
      step(1500);
      check("prereset_valid", 32'(evt_valid), 32'd1);
      ev_before = ev_count;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(evt_valid), 32'd0);
      step(3);
      evt_ready = 1'b1;
      rst = 1'b0;
      step(800);
      check("post_rst_no_event", 32'(ev_count), 32'(ev_before));
      expect_evt(1, 1'b0);
      key_level = 4'b1111;
      drain(20);
      step(5);
      check("final_empty", 32'(evt_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
